// File: rtl/ifu_fetch_queue_pkg.sv
// Shared constants and helpers for the pipelined instruction fetch unit.
// Imported by the fetch queue top, its bus interface and the response FIFO.
package ifu_fetch_queue_pkg;

  localparam int          RRESP_W      = 2;
  localparam logic [1:0]  RRESP_OKAY   = 2'b00;
  localparam logic [1:0]  RRESP_SLVERR = 2'b10;
  localparam int          DEF_ADDR_W   = 32;
  localparam int          DEF_INST_W   = 32;
  localparam logic [31:0] DEF_RESET_PC = 32'h8000_0000;

  function automatic logic resp_err(
    input logic [RRESP_W-1:0] r
  );
    return r != RRESP_OKAY;
  endfunction

endpackage

// File: rtl/ifu_fetch_queue_if.sv
// Instruction bus (AR/R) and IDU hand-off bundle of the fetch unit.
// master = fetch unit, slave = memory / decode side.
interface ifu_fetch_queue_if
  import ifu_fetch_queue_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_INST_W
);

  logic               valid_post_o;
  logic               ready_post_i;
  logic [ADDR_W-1:0]  pc_o;
  logic [DATA_W-1:0]  inst_o;
  logic               err_o;

  logic [ADDR_W-1:0]  araddr_o;
  logic               arvalid_o;
  logic               arready_i;
  logic [DATA_W-1:0]  rdata_i;
  logic [RRESP_W-1:0] rresp_i;
  logic               rvalid_i;
  logic               rready_o;

  modport master (
    output valid_post_o, pc_o, inst_o, err_o,
    output araddr_o, arvalid_o, rready_o,
    input  ready_post_i, arready_i,
    input  rdata_i, rresp_i, rvalid_i
  );

  modport slave (
    input  valid_post_o, pc_o, inst_o, err_o,
    input  araddr_o, arvalid_o, rready_o,
    output ready_post_i, arready_i,
    output rdata_i, rresp_i, rvalid_i
  );

endinterface

// File: rtl/ifu_resp_fifo.sv
// Synchronous FIFO with flush, registered head and occupancy count.
// Generic width/depth so other units can reuse it.
module ifu_resp_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_rdata,
  output logic [CW-1:0]    o_cnt
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd;
  logic [AW-1:0]    r_wr;
  logic [CW-1:0]    r_cnt;
  logic             w_full;
  logic             w_do_pop;
  logic             w_do_push;

  function automatic logic [AW-1:0] bump(
    input logic [AW-1:0] p
  );
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign w_full    = r_cnt == CW'(DEPTH);
  assign w_do_pop  = i_pop && o_valid;
  assign w_do_push = i_push && (!w_full || w_do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_do_pop)
        r_rd <= bump(r_rd);
      if (w_do_push)
        r_wr <= bump(r_wr);
      r_cnt <= r_cnt + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush)
      r_mem[r_wr] <= i_wdata;
  end

  // Head is zeroed while empty so IDU never sees stale payload.
  assign o_valid = r_cnt != '0;
  assign o_rdata = o_valid ? r_mem[r_rd] : '0;
  assign o_cnt   = r_cnt;

endmodule

// File: rtl/ifu_fetch_queue.sv
// Pipelined IFU: credit-limited in-order AR issue, drop accounting for
// fetches made stale by a WBU redirect, and a queue toward the IDU.
module ifu_fetch_queue
  import ifu_fetch_queue_pkg::*;
#(
  parameter int          ADDR_W          = DEF_ADDR_W,
  parameter int          DATA_W          = DEF_INST_W,
  parameter int          MAX_OUTSTANDING = 2,
  parameter int          FIFO_DEPTH      = 4,
  parameter [ADDR_W-1:0] RESET_PC        = DEF_RESET_PC
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  ifu_fetch_queue_if.master bus
);

  localparam int IW = $clog2(MAX_OUTSTANDING + 1);
  localparam int QW = $clog2(FIFO_DEPTH + 1);
  localparam int CW = QW + 1;
  localparam int EW = ADDR_W + DATA_W + 1;

  logic              r_run;
  logic              r_ar_pend;
  logic              r_ar_stale;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_resp_pc;
  logic [ADDR_W-1:0] r_araddr;
  logic [IW-1:0]     r_inflight;
  logic [IW-1:0]     r_drop_cnt;

  logic              w_arvalid;
  logic              w_ar_hs;
  logic              w_ar_wait;
  logic              w_r_hs;
  logic              w_drop_beat;
  logic              w_credit;
  logic              w_push;
  logic              w_pop;
  logic              w_head_valid;
  logic [QW-1:0]     w_fifo_cnt;
  logic [CW-1:0]     w_occ;
  logic [IW-1:0]     w_inflight_nx;
  logic [IW-1:0]     w_drop_nx;
  logic [EW-1:0]     w_wdata;
  logic [EW-1:0]     w_rdata;

  // Beats still owed to stale fetches do not consume queue credit.
  assign w_occ = CW'(r_inflight) - CW'(r_drop_cnt)
               + CW'(w_fifo_cnt);

  assign w_credit = (r_inflight < IW'(MAX_OUTSTANDING))
                 && (w_occ < CW'(FIFO_DEPTH));

  assign w_arvalid   = r_run && (r_ar_pend || w_credit);
  assign w_ar_hs     = w_arvalid && bus.arready_i;
  assign w_ar_wait   = w_arvalid && !bus.arready_i;
  assign w_r_hs      = r_run && bus.rvalid_i;
  assign w_drop_beat = r_drop_cnt != '0;
  assign w_pop       = w_head_valid && bus.ready_post_i;
  assign w_push      = w_r_hs && !w_drop_beat
                    && !redirect_valid_i;

  always_comb begin
    w_inflight_nx = r_inflight + IW'(w_ar_hs)
                  - IW'(w_r_hs);
    w_drop_nx     = r_drop_cnt
                  - IW'(w_r_hs && w_drop_beat)
                  + IW'(w_ar_hs && r_ar_stale);
    if (redirect_valid_i)
      w_drop_nx = w_inflight_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_run      <= 1'b0;
      r_ar_pend  <= 1'b0;
      r_ar_stale <= 1'b0;
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_araddr   <= RESET_PC;
      r_inflight <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_run      <= 1'b1;
      r_inflight <= w_inflight_nx;
      r_drop_cnt <= w_drop_nx;
      r_ar_pend  <= w_ar_wait;
      if (w_ar_wait)
        r_araddr <= bus.araddr_o;
      if (redirect_valid_i) begin
        r_fetch_pc <= redirect_pc_i;
        r_resp_pc  <= redirect_pc_i;
        r_ar_stale <= w_ar_wait;
      end else begin
        if (w_ar_hs && !r_ar_stale)
          r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
        if (w_push)
          r_resp_pc <= r_resp_pc + ADDR_W'(4);
        if (w_ar_hs)
          r_ar_stale <= 1'b0;
      end
    end
  end

  assign w_wdata = {r_resp_pc, bus.rdata_i,
                    resp_err(bus.rresp_i)};

  ifu_resp_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (redirect_valid_i),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_valid (w_head_valid),
    .o_rdata (w_rdata),
    .o_cnt   (w_fifo_cnt)
  );

  assign bus.arvalid_o    = w_arvalid;
  assign bus.araddr_o     = r_ar_pend ? r_araddr : r_fetch_pc;
  assign bus.rready_o     = r_run;
  assign bus.valid_post_o = w_head_valid;
  assign bus.pc_o         = w_rdata[EW-1 -: ADDR_W];
  assign bus.inst_o       = w_rdata[DATA_W:1];
  assign bus.err_o        = w_rdata[0];

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Directed bench for ifu_fetch_queue: 1-cycle memory with a beat budget,
// IDU sink and hand-sequenced expected PCs/addresses.
module tb_ifu_fetch_queue;

  localparam int FREE = 1 << 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  ifu_fetch_queue_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  ifu_fetch_queue dut (
    .clk              (clk),
    .rst              (rst_n),
    .redirect_valid_i (redirect_valid),
    .redirect_pc_i    (redirect_pc),
    .bus              (bus)
  );

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_bad = 0;
  int          pop_cnt = 0;
  int          r_cnt = 0;
  int          err_seen = 0;
  int          mem_allow = FREE;
  logic [31:0] mq[$];
  logic [31:0] exp_ar = 32'h8000_0000;
  logic [31:0] exp_pc = 32'h8000_0000;
  logic [31:0] err_pc = 32'h0;
  logic        stale_ar = 1'b0;
  logic [31:0] stale_addr = 32'h0;
  logic [31:0] held;
  int          p0;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Bus/IDU observer: everything sampled on the active edge.
  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
    end else begin
      if (bus.arvalid_o && bus.arready_i) begin
        if (stale_ar) begin
          check("ar_stale_addr", bus.araddr_o, stale_addr);
          stale_ar = 1'b0;
        end else begin
          check("ar_addr", bus.araddr_o, exp_ar);
          exp_ar = exp_ar + 32'd4;
        end
        mq.push_back(bus.araddr_o);
      end
      if (bus.rvalid_i && bus.rready_o) begin
        void'(mq.pop_front());
        r_cnt++;
        if (mem_allow > 0) mem_allow--;
      end
      if (redirect_valid) begin
        if (bus.arvalid_o && !bus.arready_i) begin
          stale_ar   = 1'b1;
          stale_addr = bus.araddr_o;
        end
        exp_ar = redirect_pc;
        exp_pc = redirect_pc;
      end else if (bus.valid_post_o && bus.ready_post_i) begin
        check("pop_pc", bus.pc_o, exp_pc);
        check("pop_inst", bus.inst_o, inst_of(exp_pc));
        check("pop_err", bus.err_o, exp_pc == err_pc);
        if (bus.err_o) err_seen++;
        exp_pc = exp_pc + 32'd4;
        pop_cnt++;
      end
    end
  end

  // One-cycle memory: beat appears the cycle after its AR handshake.
  always @(negedge clk) begin
    if (rst_n && mq.size() > 0 && mem_allow > 0) begin
      bus.rvalid_i = 1'b1;
      bus.rdata_i  = inst_of(mq[0]);
      bus.rresp_i  = (mq[0] == err_pc) ? 2'b10 : 2'b00;
    end else begin
      bus.rvalid_i = 1'b0;
      bus.rdata_i  = '0;
      bus.rresp_i  = 2'b00;
    end
  end

  initial begin
    rst_n            = 1'b0;
    redirect_valid   = 1'b0;
    redirect_pc      = '0;
    bus.arready_i    = 1'b1;
    bus.ready_post_i = 1'b1;
    bus.rvalid_i     = 1'b0;
    bus.rdata_i      = '0;
    bus.rresp_i      = 2'b00;

    tick(3);
    check("rst_arvalid", bus.arvalid_o, 0);
    check("rst_araddr", bus.araddr_o, 32'h8000_0000);
    check("rst_rready", bus.rready_o, 0);
    check("rst_valid", bus.valid_post_o, 0);
    check("rst_pc", bus.pc_o, 0);
    check("rst_inst", bus.inst_o, 0);
    check("rst_err", bus.err_o, 0);

    rst_n = 1'b1;
    tick(1);
    check("first_arvalid", bus.arvalid_o, 1);
    check("first_araddr", bus.araddr_o, 32'h8000_0000);
    check("run_rready", bus.rready_o, 1);
    tick(1);
    check("lat_t1_valid", bus.valid_post_o, 0);
    tick(1);
    check("lat_t2_valid", bus.valid_post_o, 1);
    check("lat_t2_pc", bus.pc_o, 32'h8000_0000);
    tick(7);
    check("throughput", pop_cnt, 7);

    bus.ready_post_i = 1'b0;
    tick(10);
    check("full_arvalid", bus.arvalid_o, 0);
    check("full_entries", r_cnt - pop_cnt, 4);
    check("full_no_pend", mq.size(), 0);
    bus.ready_post_i = 1'b1;
    tick(1);
    check("resume_arvalid", bus.arvalid_o, 1);
    tick(6);

    bus.arready_i = 1'b0;
    held = exp_ar;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("hold_arvalid", bus.arvalid_o, 1);
      check("hold_araddr", bus.araddr_o, held);
    end
    bus.arready_i = 1'b1;
    tick(6);

    mem_allow        = 0;
    bus.ready_post_i = 1'b0;
    tick(4);
    check("two_infl_arvalid", bus.arvalid_o, 0);
    check("two_infl_valid", bus.valid_post_o, 1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_1000;
    tick(1);
    redirect_valid = 1'b0;
    check("redir_valid_t1", bus.valid_post_o, 0);
    check("redir_drop", dut.r_drop_cnt, 2);
    p0               = pop_cnt;
    mem_allow        = FREE;
    bus.ready_post_i = 1'b1;
    tick(8);
    check("redir_popped", pop_cnt > p0, 1);

    bus.arready_i = 1'b0;
    tick(3);
    held           = exp_ar;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_2000;
    tick(1);
    redirect_valid = 1'b0;
    check("stale_flag", dut.r_ar_stale, 1);
    check("stale_arvalid", bus.arvalid_o, 1);
    check("stale_araddr", bus.araddr_o, held);
    p0            = pop_cnt;
    bus.arready_i = 1'b1;
    tick(8);
    check("stale_popped", pop_cnt > p0, 1);

    err_pc         = 32'h8000_3004;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_3000;
    tick(1);
    redirect_valid = 1'b0;
    tick(8);
    check("err_count", err_seen, 1);

    mem_allow = 0;
    tick(6);
    bus.ready_post_i = 1'b0;
    mem_allow        = 2;
    tick(6);
    check("p6_arvalid", bus.arvalid_o, 0);
    check("p6_infl", dut.r_inflight, 2);
    check("p6_valid", bus.valid_post_o, 1);
    bus.ready_post_i = 1'b1;
    mem_allow        = 1;
    redirect_valid   = 1'b1;
    redirect_pc      = 32'h8000_5000;
    tick(1);
    redirect_valid = 1'b0;
    check("p6_valid_t1", bus.valid_post_o, 0);
    check("p6_drop", dut.r_drop_cnt, 1);
    check("p6_infl_t1", dut.r_inflight, 1);
    p0        = pop_cnt;
    mem_allow = FREE;
    tick(10);
    check("p6_popped", pop_cnt > p0, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
